// File: rtl/nco_ctrl_pkg.sv
// Shared types and defaults for the NCO sweep controller.
// State encoding, sweep direction and default widths.
package nco_ctrl_pkg;

    localparam int PHI_W_DEF   = 20;
    localparam int DWELL_W_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRIME = 3'd1,
        S_DWELL = 3'd2,
        S_STEP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/nco_dwell_counter.sv
// Counts valid NCO samples within one sweep step; a programmed dwell of 0 acts as 1.
// reached: the count already meets the dwell; last: this cycle's sample meets it.
module nco_dwell_counter
    import nco_ctrl_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               inc,
    input  logic [DWELL_W-1:0] dwell,
    output logic               reached,
    output logic               last
);

    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W:0]   term;
    logic [DWELL_W:0]   cnt_ext;
    logic [DWELL_W:0]   cnt_plus;

    // Compare one bit wider so a full-scale dwell never wraps the terminal test.
    assign term     = (dwell == '0) ? {{DWELL_W{1'b0}}, 1'b1} : {1'b0, dwell};
    assign cnt_ext  = {1'b0, cnt};
    assign cnt_plus = cnt_ext + {{DWELL_W{1'b0}}, 1'b1};
    assign reached  = (cnt_ext >= term);
    assign last     = inc && (cnt_plus >= term);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Phase-increment sweep sequencer owning the NCO's clken and reset_n.
// Define NCO_SWEEP_PINGPONG_EN to sweep start->stop->start instead of one-way.
module nco_sweep_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int PHI_W   = PHI_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [PHI_W-1:0]   start_inc,
    input  logic [PHI_W-1:0]   stop_inc,
    input  logic [PHI_W-1:0]   step_inc,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               nco_out_valid,
    output logic [PHI_W-1:0]   nco_phi_inc,
    output logic               nco_clken,
    output logic               nco_reset_n,
    output logic               busy,
    output logic               done,
    output state_t             state
);

    state_t             state_nxt;
    dir_t               dir;
    logic [PHI_W-1:0]   cur;
    logic [PHI_W-1:0]   tgt;
    logic [PHI_W-1:0]   step_q;
    logic [PHI_W-1:0]   cur_nxt;
    logic [DWELL_W-1:0] dwell_q;
    logic [PHI_W:0]     sum_up;
    logic [PHI_W-1:0]   diff_dn;
    logic               reached;
    logic               last;
    logic               accept;
    logic               cnt_inc;
    logic               cnt_clear;
    logic               end_hit;
    logic               at_end;
    logic               turn;

    // nco_out_valid is a valid-only strobe (no ready): each high cycle in PRIME/DWELL is one counted sample.
    assign accept    = (state == S_IDLE) && start && !abort;
    assign cnt_inc   = nco_out_valid && ((state == S_PRIME) || (state == S_DWELL));
    assign cnt_clear = !((state == S_PRIME) || (state == S_DWELL));
    assign end_hit   = (state == S_DWELL) && (reached || last);
    assign at_end    = (cur == tgt) || (step_q == '0);

`ifdef NCO_SWEEP_PINGPONG_EN
    logic [PHI_W-1:0] start_q;
    logic             returning;
    assign turn = at_end && !returning && (step_q != '0) && (start_q != tgt);
`else
    assign turn = 1'b0;
`endif

    nco_dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .inc     (cnt_inc),
        .dwell   (dwell_q),
        .reached (reached),
        .last    (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_PRIME;
            S_PRIME: if (nco_out_valid) state_nxt = S_DWELL;
            S_DWELL: if (end_hit) state_nxt = (at_end && !turn) ? S_DONE : S_STEP;
            S_STEP:  state_nxt = S_DWELL;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_comb begin
        busy        = 1'b0;
        nco_clken   = 1'b0;
        nco_reset_n = 1'b0;
        done        = 1'b0;
        case (state)
            S_PRIME, S_DWELL, S_STEP: begin
                busy        = 1'b1;
                nco_clken   = 1'b1;
                nco_reset_n = 1'b1;
            end
            S_DONE: begin
                done        = 1'b1;
                nco_reset_n = 1'b1;
            end
            default: ;
        endcase
    end

    // Next increment, clamped to the target on overshoot or wrap past either end of the range.
    assign sum_up  = {1'b0, cur} + {1'b0, step_q};
    assign diff_dn = cur - step_q;

    always_comb begin
        cur_nxt = tgt;
        if (dir == DIR_UP) begin
            if (!sum_up[PHI_W] && (sum_up[PHI_W-1:0] <= tgt)) cur_nxt = sum_up[PHI_W-1:0];
        end else begin
            if ((cur >= step_q) && (diff_dn >= tgt)) cur_nxt = diff_dn;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur     <= '0;
            tgt     <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            dir     <= DIR_UP;
`ifdef NCO_SWEEP_PINGPONG_EN
            start_q   <= '0;
            returning <= 1'b0;
`endif
        end else if (accept) begin
            cur     <= start_inc;
            tgt     <= stop_inc;
            step_q  <= step_inc;
            dwell_q <= dwell;
            dir     <= (stop_inc < start_inc) ? DIR_DOWN : DIR_UP;
`ifdef NCO_SWEEP_PINGPONG_EN
            start_q   <= start_inc;
            returning <= 1'b0;
`endif
        end else if (state == S_STEP) begin
            cur <= cur_nxt;
`ifdef NCO_SWEEP_PINGPONG_EN
        end else if (end_hit && turn) begin
            returning <= 1'b1;
            tgt       <= start_q;
            dir       <= (dir == DIR_UP) ? DIR_DOWN : DIR_UP;
`endif
        end
    end

    assign nco_phi_inc = cur;

endmodule
